// File: rtl/dac_sample_fifo.sv
// Elastic sample FIFO feeding the AD5543 SPI DAC driver; holds the last code on starvation.
// Optional DAC_TWOS_COMP_EN: convert two's complement input to offset binary on load.
module dac_sample_fifo #(
  parameter int              DW        = 16,
  parameter int              DEPTH     = 16,
  parameter logic [DW-1:0]   IDLE_CODE = {1'b1, {(DW-1){1'b0}}},
  parameter int              CW        = 16
) (
  input  logic                       s_axis_aclk,
  input  logic                       s_axis_areset,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [DW-1:0]              s_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [DW-1:0]              m_axis_tdata,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [CW-1:0]              underrun_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          load;
  logic          drain;
  logic          underrun;

  function automatic logic [DW-1:0] to_dac(input logic [DW-1:0] d);
`ifdef DAC_TWOS_COMP_EN
    return d ^ {1'b1, {(DW-1){1'b0}}};
`else
    return d;
`endif
  endfunction

  // Reset gates ready so the upstream never pushes into a block being cleared.
  assign s_axis_tready = en & ~flush & ~s_axis_areset & (level < LW'(DEPTH));

  always_comb begin
    push     = 1'b0;
    load     = 1'b0;
    drain    = 1'b0;
    underrun = 1'b0;
    if (en) begin
      push     = s_axis_tvalid & s_axis_tready;
      load     = ~flush & (~m_axis_tvalid | m_axis_tready) & (level != LW'(0));
      drain    = ~flush & m_axis_tready & (level == LW'(0));
      underrun = m_axis_tready & ~m_axis_tvalid;
    end else begin
      push     = 1'b0;
    end
  end

  always_ff @(posedge s_axis_aclk) begin
    if (push) begin
      mem[wr_ptr] <= s_axis_tdata;
    end
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      m_axis_tdata  <= IDLE_CODE;
      m_axis_tvalid <= 1'b0;
    end else if (en && flush) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      m_axis_tdata  <= IDLE_CODE;
      m_axis_tvalid <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (load) begin
        rd_ptr        <= rd_ptr + AW'(1);
        m_axis_tdata  <= to_dac(mem[rd_ptr]);
        m_axis_tvalid <= 1'b1;
      end else if (drain) begin
        m_axis_tvalid <= 1'b0;
      end
      // A push and a load in the same cycle leave occupancy unchanged.
      if (push && !load) begin
        level <= level + LW'(1);
      end else if (load && !push) begin
        level <= level - LW'(1);
      end
    end
  end

  // Underruns count even during flush; only reset clears them.
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      underrun_cnt <= '0;
    end else if (underrun && (underrun_cnt != {CW{1'b1}})) begin
      underrun_cnt <= underrun_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_dac_sample_fifo.sv
// Directed self-checking bench for dac_sample_fifo (DEPTH=16, plus a CW=2 instance for saturation).
module tb_dac_sample_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        flush;
  logic        s_tvalid;
  logic        s_tready;
  logic [15:0] s_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [15:0] m_tdata;
  logic [4:0]  level;
  logic [15:0] ucnt;

  logic        m2_tready;
  logic        s2_tready;
  logic        m2_tvalid;
  logic [15:0] m2_tdata;
  logic [2:0]  level2;
  logic [1:0]  ucnt2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dac_sample_fifo #(.DW(16), .DEPTH(16), .CW(16)) dut (
    .s_axis_aclk(clk), .s_axis_areset(rst), .en(en), .flush(flush),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .level(level), .underrun_cnt(ucnt)
  );

  dac_sample_fifo #(.DW(16), .DEPTH(4), .CW(2)) dut2 (
    .s_axis_aclk(clk), .s_axis_areset(rst), .en(en), .flush(1'b0),
    .s_axis_tvalid(1'b0), .s_axis_tready(s2_tready), .s_axis_tdata(16'h0000),
    .m_axis_tvalid(m2_tvalid), .m_axis_tready(m2_tready), .m_axis_tdata(m2_tdata),
    .level(level2), .underrun_cnt(ucnt2)
  );

  function automatic logic [15:0] conv(input logic [15:0] d);
`ifdef DAC_TWOS_COMP_EN
    return d ^ 16'h8000;
`else
    return d;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; flush = 1'b0; s_tvalid = 1'b0; s_tdata = 16'h0000;
    m_tready = 1'b0; m2_tready = 1'b0;
    step(); step();
    check("rst_tready", s_tready, 1'b0);
    check("rst_tdata", m_tdata, 16'h8000);
    check("rst_tvalid", m_tvalid, 1'b0);
    check("rst_level", level, 5'd0);
    check("rst_ucnt", ucnt, 16'd0);
    rst = 1'b0;
    #1;
    check("post_rst_tready", s_tready, 1'b1);

    // CW=2 saturation on the second instance
    m2_tready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    m2_tready = 1'b0;
    check("ucnt_sat", ucnt2, 2'd3);

    // Latency and ordering
    s_tvalid = 1'b1; s_tdata = 16'h1234;
    step();
    check("lat_level1", level, 5'd1);
    check("lat_notyet", m_tvalid, 1'b0);
    s_tdata = 16'h5678;
    step();
    s_tvalid = 1'b0;
    check("lat_data", m_tdata, conv(16'h1234));
    check("lat_valid", m_tvalid, 1'b1);
    check("lat_level2", level, 5'd1);
    m_tready = 1'b1;
    step();
    m_tready = 1'b0;
    check("order_data", m_tdata, conv(16'h5678));
    check("order_level", level, 5'd0);

    // Underrun: first pulse consumes the fresh sample, next two count
    m_tready = 1'b1;
    step(); step(); step();
    m_tready = 1'b0;
    check("ur_hold", m_tdata, conv(16'h5678));
    check("ur_valid", m_tvalid, 1'b0);
    check("ur_cnt2", ucnt, 16'd2);
    m_tready = 1'b1;
    step();
    m_tready = 1'b0;
    check("ur_cnt3", ucnt, 16'd3);

    // Full: 17 pushes, one goes to the output register
    s_tvalid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      s_tdata = 16'h0100 + 16'(i);
      check("full_ready", s_tready, 1'b1);
      step();
    end
    s_tvalid = 1'b0;
    check("full_level", level, 5'd16);
    check("full_tready", s_tready, 1'b0);
    check("full_head", m_tdata, conv(16'h0100));
    m_tready = 1'b1;
    #1;
    check("full_tready_pulse", s_tready, 1'b0);
    step();
    m_tready = 1'b0;
    check("full_next", m_tdata, conv(16'h0101));
    check("full_level15", level, 5'd15);
    check("full_tready_back", s_tready, 1'b1);
    check("full_ucnt", ucnt, 16'd3);

    // Flush, refill to level 5, flush with a concurrent push
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl1_level", level, 5'd0);
    check("fl1_tdata", m_tdata, 16'h8000);
    s_tvalid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_tdata = 16'h0A00 + 16'(i);
      step();
    end
    check("fl_level5", level, 5'd5);
    s_tdata = 16'hDEAD; flush = 1'b1;
    #1;
    check("fl_tready", s_tready, 1'b0);
    step();
    flush = 1'b0; s_tvalid = 1'b0;
    check("fl_level", level, 5'd0);
    check("fl_tdata", m_tdata, 16'h8000);
    check("fl_tvalid", m_tvalid, 1'b0);
    step(); step(); step();
    check("fl_nodead", m_tdata, 16'h8000);
    check("fl_nodead_v", m_tvalid, 1'b0);
    flush = 1'b1; m_tready = 1'b1;
    step();
    flush = 1'b0; m_tready = 1'b0;
    check("fl_ur", ucnt, 16'd4);

    // Two's-complement conversion vectors
    s_tvalid = 1'b1;
    s_tdata = 16'h0000; step();
    s_tdata = 16'h7FFF; step();
    s_tdata = 16'h8000; step();
    s_tvalid = 1'b0;
    check("tc_0", m_tdata, conv(16'h0000));
    check("tc_level", level, 5'd2);
    m_tready = 1'b1; step(); m_tready = 1'b0;
    check("tc_1", m_tdata, conv(16'h7FFF));
    m_tready = 1'b1; step(); m_tready = 1'b0;
    check("tc_2", m_tdata, conv(16'h8000));

    // Enable low freezes everything
    en = 1'b0; s_tvalid = 1'b1; s_tdata = 16'h4321; m_tready = 1'b1;
    #1;
    check("en_tready", s_tready, 1'b0);
    step(); step();
    check("en_level", level, 5'd0);
    check("en_valid", m_tvalid, 1'b1);
    check("en_ucnt", ucnt, 16'd4);
    en = 1'b1; s_tvalid = 1'b0; m_tready = 1'b0;

    // Async reset mid-traffic
    s_tvalid = 1'b1; s_tdata = 16'h1111;
    step(); step(); step();
    rst = 1'b1;
    #1;
    check("t1_tdata", m_tdata, 16'h8000);
    check("t1_tvalid", m_tvalid, 1'b0);
    check("t1_level", level, 5'd0);
    check("t1_ucnt", ucnt, 16'd0);
    check("t1_tready", s_tready, 1'b0);
    step();
    check("t1_tready_held", s_tready, 1'b0);
    rst = 1'b0; s_tvalid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
